fir_filter_param: RTL and testbench

- Parametrised, streaming, unsigned FIR filter with run-time programmable coefficients.
- Successor to the fixed 4-tap {2,1,1,1} sum block.
- Adds valid-gated sample shifting, warm-up suppression, a flush control, a coefficient write port, a two-stage pipeline and output saturation.
- Sits between a sample source and downstream accumulation/display logic on the single system clock.

---
 rtl/fir_filter_param.sv | 166 ++++++++++++++++
 tb/tb_fir_filter_param.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_param.sv
// ---------------------------------------------------------------------------
// fir_filter_param
//
// Streaming, unsigned, parametrised FIR filter with run-time programmable
// coefficients. Each accepted sample forms a window w[0..TAPS-1]
// (w[0] = current sample, w[k] = k-th previously accepted sample).
// Stage 1 registers the per-tap products, and stage 2 sums and saturates them.
// Results start only once TAPS real samples are in the window.
//
// Handshake: x is consumed on every rising clk edge where x_valid=1; there is
// no back-pressure. y_valid is a one-cycle strobe, two edges after the
// accepting edge, and y holds its value between strobes.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-high reset
//   x          in   DATA_W-bit unsigned input sample
//   x_valid    in   sample strobe
//   flush      in   synchronous clear of delay line and warm-up state
//   coef_we    in   coefficient write enable
//   coef_addr  in   tap index to write (0 = current sample)
//   coef_data  in   coefficient value
//   y          out  OUT_W-bit saturated filter result (registered)
//   y_valid    out  one-cycle strobe marking a new y
//   ovf        out  sticky saturation flag, cleared only by rst
// ---------------------------------------------------------------------------
module fir_filter_param #(
    parameter int DATA_W = 4,
    parameter int TAPS   = 4,
    parameter int COEF_W = 4,
    parameter int OUT_W  = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         x,
    input  logic                      x_valid,
    input  logic                      flush,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic [COEF_W-1:0]         coef_data,
    output logic [OUT_W-1:0]          y,
    output logic                      y_valid,
    output logic                      ovf
);

    localparam int AW     = $clog2(TAPS);
    localparam int CNT_W  = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + $clog2(TAPS) + 1;
    // The sum is kept at least one bit wider than y, so the saturation
    // compare works uniformly even when OUT_W exceeds the natural
    // accumulator width.
    localparam int SUM_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;

    localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(TAPS - 1);
    localparam logic [AW:0]      TAPS_L   = (AW + 1)'(TAPS);
    localparam logic [SUM_W-1:0] Y_MAX    = {{(SUM_W - OUT_W){1'b0}}, {OUT_W{1'b1}}};

    // Programmable coefficients
    logic [COEF_W-1:0] coef_q [TAPS];

    // Previously accepted samples: dl_q[k] holds w[k+1]
    logic [DATA_W-1:0] dl_q [TAPS-1];
    logic [CNT_W-1:0]  fill_q;

    // Stage 1 registers
    logic [PROD_W-1:0] p_q [TAPS];
    logic              v1_q;

    // Stage 2 / output registers
    logic [OUT_W-1:0]  y_q;
    logic              y_valid_q;
    logic              ovf_q;

    // Combinational next-state terms
    logic [DATA_W-1:0] w_c   [TAPS];
    logic [PROD_W-1:0] p_d   [TAPS];
    logic [SUM_W-1:0]  sum_c;
    logic [OUT_W-1:0]  y_d;
    logic              sat_d;
    logic              primed_c;
    logic              addr_ok_c;

    assign primed_c  = (fill_q == FILL_MAX);
    assign addr_ok_c = ({1'b0, coef_addr} < TAPS_L);

    // Current window and products, using the coefficients in force before
    // this edge so that a same-edge coefficient write is not seen yet.
    always_comb begin
        w_c[0] = x;
        for (int k = 1; k < TAPS; k++) begin
            w_c[k] = dl_q[k-1];
        end
        for (int k = 0; k < TAPS; k++) begin
            p_d[k] = PROD_W'(coef_q[k]) * PROD_W'(w_c[k]);
        end
    end

    // Stage 2 adder tree and saturation
    always_comb begin
        sum_c = '0;
        for (int k = 0; k < TAPS; k++) begin
            sum_c = sum_c + SUM_W'(p_q[k]);
        end
        sat_d = (sum_c > Y_MAX);
        y_d   = sat_d ? {OUT_W{1'b1}} : sum_c[OUT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                coef_q[k] <= (k == 0) ? COEF_W'(2) : COEF_W'(1);
                p_q[k]    <= '0;
            end
            for (int k = 0; k < TAPS - 1; k++) begin
                dl_q[k] <= '0;
            end
            fill_q    <= '0;
            v1_q      <= 1'b0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (coef_we && addr_ok_c) begin
                coef_q[coef_addr] <= coef_data;
            end

            // Flush wins over a same-edge sample, which is dropped.
            // Stage 2 below still completes whatever v1_q already holds.
            if (flush) begin
                for (int k = 0; k < TAPS - 1; k++) begin
                    dl_q[k] <= '0;
                end
                fill_q <= '0;
                v1_q   <= 1'b0;
            end else if (x_valid) begin
                dl_q[0] <= x;
                for (int k = 1; k < TAPS - 1; k++) begin
                    dl_q[k] <= dl_q[k-1];
                end
                if (!primed_c) begin
                    fill_q <= fill_q + CNT_W'(1);
                end
                for (int k = 0; k < TAPS; k++) begin
                    p_q[k] <= p_d[k];
                end
                v1_q <= primed_c;
            end else begin
                v1_q <= 1'b0;
            end

            if (v1_q) begin
                y_q       <= y_d;
                y_valid_q <= 1'b1;
                ovf_q     <= ovf_q | sat_d;
            end else begin
                y_valid_q <= 1'b0;
            end
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_fir_filter_param.sv
// ---------------------------------------------------------------------------
// tb_fir_filter_param
//
// Two instances share one stimulus stream: the default build (OUT_W=12) and a
// narrow build (OUT_W=8) that exercises saturation. The reference model keeps
// the accepted-sample history as a queue plus a coefficient array. It
// computes each window sum arithmetically and schedules it for the edge on
// which it must appear.
// ---------------------------------------------------------------------------
module tb_fir_filter_param;

    localparam int TAPS = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  x;
    logic        x_valid;
    logic        flush;
    logic        coef_we;
    logic [1:0]  coef_addr;
    logic [3:0]  coef_data;

    logic [11:0] y12;
    logic        yv12;
    logic        ovf12;
    logic [7:0]  y8;
    logic        yv8;
    logic        ovf8;

    fir_filter_param #(.DATA_W(4), .TAPS(TAPS), .COEF_W(4), .OUT_W(12)) dut (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .flush(flush),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .y(y12), .y_valid(yv12), .ovf(ovf12)
    );

    fir_filter_param #(.DATA_W(4), .TAPS(TAPS), .COEF_W(4), .OUT_W(8)) dut8 (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .flush(flush),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .y(y8), .y_valid(yv8), .ovf(ovf8)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        int due;
        int sum;
    } exp_t;

    exp_t exp_q[$];
    int   hist[$];
    int   m_coef[TAPS];
    int   ey12, ey8;
    logic eo12, eo8;
    int   cyc;
    int   n_checks;
    int   n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int sat(input int s, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (s > mx) ? mx : s;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        hist.delete();
        m_coef[0] = 2;
        for (int k = 1; k < TAPS; k++) m_coef[k] = 1;
        ey12 = 0;
        ey8  = 0;
        eo12 = 1'b0;
        eo8  = 1'b0;
    endtask

    task automatic check_outputs();
        exp_t e;
        logic ev;
        ev = 1'b0;
        if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            ev = 1'b1;
            ey12 = sat(e.sum, 12);
            ey8  = sat(e.sum, 8);
            if (e.sum > 4095) eo12 = 1'b1;
            if (e.sum > 255)  eo8  = 1'b1;
        end
        check("yv12",  32'(yv12),  32'(ev));
        check("y12",   32'(y12),   32'(ey12));
        check("ovf12", 32'(ovf12), 32'(eo12));
        check("yv8",   32'(yv8),   32'(ev));
        check("y8",    32'(y8),    32'(ey8));
        check("ovf8",  32'(ovf8),  32'(eo8));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic xv, input logic [3:0] xd, input logic fl,
                        input logic we, input logic [1:0] wa, input logic [3:0] wd);
        int s;
        x         = xd;
        x_valid   = xv;
        flush     = fl;
        coef_we   = we;
        coef_addr = wa;
        coef_data = wd;
        // Model the coming edge: the sample uses coefficients before the write.
        if (fl) begin
            hist.delete();
        end else if (xv) begin
            hist.push_front(int'(xd));
            if (hist.size() > TAPS) void'(hist.pop_back());
            if (hist.size() == TAPS) begin
                s = 0;
                for (int k = 0; k < TAPS; k++) s += m_coef[k] * hist[k];
                exp_q.push_back('{due: cyc + 2, sum: s});
            end
        end
        if (we) m_coef[wa] = int'(wd);
        @(posedge clk);
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic sample(input logic [3:0] xd);
        step(1'b1, xd, 1'b0, 1'b0, 2'd0, 4'd0);
    endtask

    task automatic idle();
        step(1'b0, 4'($urandom_range(0, 15)), 1'b0, 1'b0, 2'd0, 4'd0);
    endtask

    task automatic do_flush(input logic xv, input logic [3:0] xd);
        step(xv, xd, 1'b1, 1'b0, 2'd0, 4'd0);
    endtask

    task automatic write_coef(input logic [1:0] wa, input logic [3:0] wd);
        step(1'b0, 4'd0, 1'b0, 1'b1, wa, wd);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        x = '0; x_valid = 1'b0; flush = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_yv12", 32'(yv12), 32'd0);
        check("rst_y12",  32'(y12),  32'd0);
        check("rst_ovf8", 32'(ovf8), 32'd0);
        rst = 1'b0;

        // Default coefficients, continuous stream 1..5
        for (int i = 1; i <= 5; i++) sample(4'(i));
        check("t1_y14", 32'(y12), 32'd14);
        idle();
        check("t1_y19", 32'(y12), 32'd19);
        idle();

        // Same stream with a 3-cycle gap between samples 4 and 5
        do_flush(1'b0, 4'd0);
        for (int i = 1; i <= 4; i++) sample(4'(i));
        repeat (3) idle();
        sample(4'd5);
        check("gap_hold14", 32'(y12), 32'd14);
        idle();
        check("gap_y19", 32'(y12), 32'd19);

        // Coefficient writes mid-stream: coef[0]=0 on the edge of sample 5
        do_flush(1'b0, 4'd0);
        for (int i = 1; i <= 4; i++) sample(4'(i));
        step(1'b1, 4'd5, 1'b0, 1'b1, 2'd0, 4'd0);
        write_coef(2'd3, 4'd3);
        check("coef_old19", 32'(y12), 32'd19);
        sample(4'd6);
        idle();
        check("coef_new18", 32'(y12), 32'd18);

        // Saturation: all coefficients 15, x=15 continuous, then x=0
        for (int k = 0; k < TAPS; k++) write_coef(2'(k), 4'd15);
        repeat (6) sample(4'd15);
        check("sat_y12", 32'(y12), 32'd900);
        check("sat_y8",  32'(y8),  32'd255);
        repeat (6) sample(4'd0);
        check("sat_ovf8_sticky", 32'(ovf8), 32'd1);
        check("sat_y8_zero",     32'(y8),   32'd0);

        // Flush with a sample on the same edge after priming
        for (int i = 1; i <= 4; i++) sample(4'(i));
        do_flush(1'b1, 4'd9);
        for (int i = 10; i <= 13; i++) sample(4'(i));
        idle();
        check("flush_y12", 32'(y12), 32'd690);

        // Asynchronous reset between edges while results are streaming
        for (int i = 1; i <= 6; i++) sample(4'(i));
        #3 rst = 1'b1;
        #1;
        check("arst_yv12", 32'(yv12), 32'd0);
        check("arst_y12",  32'(y12),  32'd0);
        check("arst_ovf8", 32'(ovf8), 32'd0);
        #1 rst = 1'b0;
        model_reset();
        for (int i = 1; i <= 5; i++) sample(4'(i));
        check("arst_y14", 32'(y12), 32'd14);
        idle();
        check("arst_y19", 32'(y12), 32'd19);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            step(logic'($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 15)),
                 logic'($urandom_range(0, 24) == 0),
                 logic'($urandom_range(0, 7) == 0),
                 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)));
        end
        repeat (3) idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
